// File: rtl/seq_bitwise_unit_if.sv
// rtl/seq_bitwise_unit_if.sv - request/response bundle for the slice-serial bitwise unit
//
// Purpose: groups the operation request (start, op, a, b) and the status/result
// return (busy, done, result, zero) between the ALU controller and the unit.
// Ports (signals):
//   start   controller -> unit  request, sampled only when the unit is not busy
//   op      controller -> unit  00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b    controller -> unit  operands, latched on an accepted start
//   busy    unit -> controller  high while slices are being evaluated
//   done    unit -> controller  one-cycle pulse, result valid
//   result  unit -> controller  registered result, held until the next accepted start
//   zero    unit -> controller  result == 0, updated together with done
// Modports: master = ALU controller side, slave = bitwise unit side.

interface seq_bitwise_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  busy,
        input  done,
        input  result,
        input  zero
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output busy,
        output done,
        output result,
        output zero
    );
endinterface

// File: rtl/seq_bitwise_unit.sv
// rtl/seq_bitwise_unit.sv - multi-cycle slice-serial bitwise logic unit (AND/OR/XOR/NOR)
//
// Purpose: evaluates a bitwise operation on two WIDTH-bit operands, SLICE bits
// per clock, LSB slice first, with a start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset; aborts any operation in flight
//   bus    seq_bitwise_unit_if.slave: start/op/a/b in, busy/done/result/zero out
// Parameters:
//   WIDTH  operand and result width in bits
//   SLICE  bits evaluated per RUN cycle; WIDTH must be a multiple of SLICE

module seq_bitwise_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_bitwise_unit_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("seq_bitwise_unit: WIDTH must be a multiple of SLICE");
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_next_result;

    // A new request is taken from IDLE or DONE; DONE accepting gives
    // back-to-back operation with no idle cycle in between.
    assign w_accept = bus.start && (r_state != ST_RUN);
    assign w_last   = (r_idx == LAST_IDX);

    // Only one SLICE-wide operand pair is routed to the logic per cycle.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_a_slice = r_a[s*SLICE +: SLICE];
                w_b_slice = r_b[s*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        w_slice = '0;
        case (r_op)
            OP_AND:  w_slice = w_a_slice & w_b_slice;
            OP_OR:   w_slice = w_a_slice | w_b_slice;
            OP_XOR:  w_slice = w_a_slice ^ w_b_slice;
            OP_NOR:  w_slice = ~(w_a_slice | w_b_slice);
            default: w_slice = '0;
        endcase
    end

    // Result as it will look after this edge; also feeds the zero flag so the
    // slice written on the final edge is included.
    always_comb begin
        w_next_result = r_result;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_next_result[s*SLICE +: SLICE] = w_slice;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_AND;
            r_idx    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_op     <= bus.op;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_result <= w_next_result;
                    if (w_last) begin
                        r_zero  <= (w_next_result == '0);
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
    assign bus.zero   = r_zero;

endmodule

// File: tb/tb_seq_bitwise_unit.sv
// tb/tb_seq_bitwise_unit.sv - directed and swept checks for seq_bitwise_unit

module tb_seq_bitwise_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    seq_bitwise_unit_if #(.WIDTH(32)) if0 ();
    seq_bitwise_unit_if #(.WIDTH(16)) if1 ();
    seq_bitwise_unit_if #(.WIDTH(64)) if2 ();

    seq_bitwise_unit #(.WIDTH(32), .SLICE(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    seq_bitwise_unit #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    seq_bitwise_unit #(.WIDTH(64), .SLICE(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic st, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        case (sel)
            0: begin if0.start = st; if0.op = op; if0.a = a[31:0]; if0.b = b[31:0]; end
            1: begin if1.start = st; if1.op = op; if1.a = a[15:0]; if1.b = b[15:0]; end
            default: begin if2.start = st; if2.op = op; if2.a = a; if2.b = b; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic st);
        case (sel)
            0: if0.start = st;
            1: if1.start = st;
            default: if2.start = st;
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if0.done;
            1: return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if0.busy;
            1: return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic get_zero(input int sel);
        case (sel)
            0: return if0.zero;
            1: return if1.zero;
            default: return if2.zero;
        endcase
    endfunction

    function automatic logic [63:0] get_result(input int sel);
        case (sel)
            0: return {32'd0, if0.result};
            1: return {48'd0, if1.result};
            default: return if2.result;
        endcase
    endfunction

    // Truth-table reference, masked to the configured width.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int width);
        logic [63:0] r;
        logic [63:0] mask;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return r & mask;
    endfunction

    // Issues one operation; lat counts edges with the accepting edge as 1.
    task automatic do_op(input int sel, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output logic z,
                         output int lat, output int busy_n);
        drive(sel, 1'b1, op, a, b);
        tick();
        set_start(sel, 1'b0);
        lat    = 1;
        busy_n = 0;
        while (!get_done(sel) && lat < 100) begin
            if (get_busy(sel)) busy_n++;
            tick();
            lat++;
        end
        res = get_result(sel);
        z   = get_zero(sel);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] a;
        logic [63:0] b;
        logic        z;
        int          lat;
        int          busy_n;
        int          dones;
        int          d1;
        int          d2;
        logic [63:0] r1;
        logic [63:0] r2;

        drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(1, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(2, 1'b0, 2'b00, 64'd0, 64'd0);

        // Reset, then idle
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy",   {63'd0, if0.busy}, 64'd0);
        check("rst_done",   {63'd0, if0.done}, 64'd0);
        check("rst_result", get_result(0),     64'd0);
        check("rst_zero",   {63'd0, if0.zero}, 64'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if0.done) dones++;
        end
        check("idle_no_done", 64'(dones), 64'd0);

        // OR, default configuration
        do_op(0, 2'b01, 64'hF0F0_0000, 64'h0000_0F0F, res, z, lat, busy_n);
        check("or_latency", 64'(lat),     64'd5);
        check("or_busy_n",  64'(busy_n),  64'd4);
        check("or_busy_at_done", {63'd0, if0.busy}, 64'd0);
        check("or_result",  res,          64'hF0F0_0F0F);
        check("or_zero",    {63'd0, z},   64'd0);
        tick();
        check("or_done_one_cycle", {63'd0, if0.done}, 64'd0);
        check("or_result_held",    get_result(0),     64'hF0F0_0F0F);

        // All ops and zero flag
        do_op(0, 2'b00, 64'hAAAA_AAAA, 64'h5555_5555, res, z, lat, busy_n);
        check("and_result", res,        64'd0);
        check("and_zero",   {63'd0, z}, 64'd1);
        do_op(0, 2'b10, 64'hAAAA_AAAA, 64'h5555_5555, res, z, lat, busy_n);
        check("xor_result", res,        64'hFFFF_FFFF);
        check("xor_zero",   {63'd0, z}, 64'd0);
        set_start(0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("xor_held_idle", get_result(0), 64'hFFFF_FFFF);
        // Accepting start clears result but zero stays until the next done
        drive(0, 1'b1, 2'b11, 64'hFFFF_0000, 64'h0000_FFFF);
        tick();
        set_start(0, 1'b0);
        check("start_clears_result", get_result(0),     64'd0);
        check("start_keeps_zero",    {63'd0, if0.zero}, 64'd0);
        lat = 1;
        while (!if0.done && lat < 100) begin
            tick();
            lat++;
        end
        check("nor_latency", 64'(lat),          64'd5);
        check("nor_result",  get_result(0),     64'd0);
        check("nor_zero",    {63'd0, if0.zero}, 64'd1);

        // Operand stability and ignored start
        tick();
        drive(0, 1'b1, 2'b00, 64'h1234_5678, 64'h0F0F_0F0F);
        tick();
        drive(0, 1'b1, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        tick();
        set_start(0, 1'b0);
        dones = 0;
        r1    = '0;
        for (int i = 0; i < 12; i++) begin
            if (if0.done) begin
                dones++;
                r1 = get_result(0);
            end
            tick();
        end
        check("stable_done_count", 64'(dones), 64'd1);
        check("stable_result",     r1,         64'h0204_0608);

        // Back-to-back with start held high
        drive(0, 1'b1, 2'b01, 64'h0000_0001, 64'h0000_0000);
        tick();
        d1 = 0;
        d2 = 0;
        r1 = '0;
        r2 = '0;
        for (int e = 2; e < 40 && d2 == 0; e++) begin
            tick();
            if (if0.done) begin
                if (d1 == 0) begin
                    d1 = e;
                    r1 = get_result(0);
                    drive(0, 1'b1, 2'b01, 64'h0000_0F00, 64'h0000_0000);
                end else begin
                    d2 = e;
                    r2 = get_result(0);
                    set_start(0, 1'b0);
                end
            end
        end
        check("b2b_first_done", 64'(d1),      64'd5);
        check("b2b_spacing",    64'(d2 - d1), 64'd5);
        check("b2b_result1",    r1,           64'h0000_0001);
        check("b2b_result2",    r2,           64'h0000_0F00);
        tick();

        // Reset on the 2nd RUN cycle
        drive(0, 1'b1, 2'b01, 64'hFFFF_FFFF, 64'h0000_0000);
        tick();
        set_start(0, 1'b0);
        tick();
        check("mid_partial_lsb_first", get_result(0), 64'h0000_00FF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy",   {63'd0, if0.busy}, 64'd0);
        check("mid_rst_result", get_result(0),     64'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (if0.done) dones++;
            tick();
        end
        check("mid_rst_no_done", 64'(dones), 64'd0);

        // Parameter sweep: WIDTH=16/SLICE=16 (sel 1), WIDTH=64/SLICE=4 (sel 2)
        for (int sel = 1; sel <= 2; sel++) begin
            for (int op = 0; op < 4; op++) begin
                for (int i = 0; i < 100; i++) begin
                    if (i == 0) begin
                        a = 64'd0;
                        b = 64'd0;
                    end else if (i == 1) begin
                        a = {64{1'b1}};
                        b = {64{1'b1}};
                    end else begin
                        a = {$urandom(), $urandom()};
                        b = {$urandom(), $urandom()};
                    end
                    do_op(sel, 2'(op), a, b, res, z, lat, busy_n);
                    check($sformatf("sweep%0d_op%0d_lat", sel, op), 64'(lat),
                          (sel == 1) ? 64'd2 : 64'd17);
                    check($sformatf("sweep%0d_op%0d_res", sel, op), res,
                          ref_op(2'(op), a, b, (sel == 1) ? 16 : 64));
                    check($sformatf("sweep%0d_op%0d_zero", sel, op), {63'd0, z},
                          {63'd0, ref_op(2'(op), a, b, (sel == 1) ? 16 : 64) == 64'd0});
                end
            end
            set_start(sel, 1'b0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_bitwise_unit.md
Name: seq_bitwise_unit

Overview:
- Parametrised, multi-cycle bitwise logic unit for the ALU datapath.
- Generalises the fixed 32-bit single-function OR array to:
  - configurable operand width;
  - four selectable operations;
  - slice-serial evaluation, SLICE bits per clock;
  - start/busy/done handshake.
- Sits beside the arithmetic units; the ALU controller issues an operation and waits for done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits evaluated per RUN cycle. WIDTH % SLICE must be 0. SLICE == WIDTH gives a single RUN cycle.
- NSLICE (localparam), WIDTH/SLICE, number of RUN cycles.

Ports:
- clk     input   1       rising-edge clock.
- reset   input   1       synchronous, active-high reset.
- start   input   1       request; sampled only when not busy.
- op      input   2       operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- a       input   WIDTH   operand A; latched on an accepted start.
- b       input   WIDTH   operand B; latched on an accepted start.
- busy    output  1       high while in RUN.
- done    output  1       one-cycle pulse; result is valid.
- result  output  WIDTH   registered result; held until the next accepted start.
- zero    output  1       high when result == 0; updated together with done, then held.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. Everything is registered on the clk rising edge.
- Reset (reset high at an edge):
  - state = IDLE, busy = 0, done = 0, result = 0, zero = 0, slice index = 0.
  - Reset overrides start.
  - Reset in RUN aborts the operation. No done pulse is issued and no partial result remains.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at an edge: latch a, b and op into internal registers; clear result to 0; idx = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1):
  - Each edge writes result[idx*SLICE +: SLICE] = op(a_l, b_l) on that slice, then idx = idx + 1.
  - On the edge that writes slice NSLICE-1, go to DONE and set zero = (final result == 0). zero must include the slice written on that same edge.
  - start is ignored in RUN.
  - Changes on a, b or op during RUN have no effect.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - start = 1 here is accepted like in IDLE, which allows back-to-back operations with no idle cycle. Otherwise go to IDLE.
- Latency: counting the edge that accepts start as edge 1, done is high after edge NSLICE+1. Default configuration: 5 edges.
- Throughput: one operation per NSLICE+1 cycles with start held high.
- Result visibility:
  - result shows partial slices while busy. Consumers use it only when done = 1 or after done.
  - result and zero hold their values in IDLE until the next accepted start. That start clears result to 0 but leaves zero unchanged until the next done.
- Slice ordering: LSB slice first. idx wraps to 0 on the transition to DONE.
- Width rules: purely bitwise, no carry between slices. NOR is applied per bit, ~(a|b).

Test Plan:
- Reset, then idle:
  - Stimulus: hold reset for 2 cycles, then release.
  - Required: busy = 0, done = 0, result = 0, zero = 0.
  - Required: start held low for 10 cycles produces no done pulse.
- OR operation, default parameters:
  - Stimulus: a = 0xF0F0_0000, b = 0x0000_0F0F, op = 01, pulse start.
  - Required: busy high for 4 cycles, then done for 1 cycle, result = 0xF0F0_0F0F, zero = 0.
  - Required: done appears after edge 5 counting the accepting edge.
- All ops and zero flag:
  - AND of 0xAAAA_AAAA with 0x5555_5555 gives 0, zero = 1.
  - XOR of the same operands gives 0xFFFF_FFFF.
  - NOR of 0xFFFF_0000 with 0x0000_FFFF gives 0, zero = 1.
- Operand stability and ignored start:
  - Stimulus: accept a start, then during RUN change a and b to 0xFFFF_FFFF and pulse start.
  - Required: result matches the originally latched operands; exactly one done pulse.
- Back-to-back and reset mid-operation:
  - Stimulus: hold start high for two operations.
  - Required: two done pulses 5 cycles apart.
  - Stimulus: assert reset on the 2nd RUN cycle.
  - Required: next cycle busy = 0, result = 0; no done pulse.
- Parameter sweep:
  - Configurations: WIDTH = 16 with SLICE = 16, and WIDTH = 64 with SLICE = 4.
  - Required latency: 2 and 17 edges respectively.
  - Required: random operands (100 per op) match the reference model.
